time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper_pkg.sv | 18 +
 rtl/mod_n_counter.sv | 33 +++
 rtl/time_keeper.sv | 126 ++++++++++++
 tb/tb_time_keeper.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_keeper_pkg.sv
// Shared limits, alarm FSM encoding and load-validation helper for the time_keeper block.
package time_keeper_pkg;

  localparam logic [4:0] MAX_HOURS   = 5'd23;
  localparam logic [5:0] MAX_MINUTES = 6'd59;
  localparam logic [5:0] MAX_SECONDS = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    DONE    = 2'd2
  } alarm_state_e;

  function automatic logic hhmm_valid(input logic [4:0] hours, input logic [5:0] minutes);
    return (hours <= MAX_HOURS) && (minutes <= MAX_MINUTES);
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N up counter with synchronous load (load beats enable) and a carry-out
// that fires on the enabled wrap from MODULUS-1 back to 0.
module mod_n_counter #(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             carry
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // A load swallows the increment, so it must not ripple a carry upward either.
  assign carry = enable && !load && (count == LAST);

  // NOTE: registered state always uses non-blocking assignments so every flop
  // samples pre-edge values, regardless of how always blocks are ordered.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/time_keeper.sv
// Time-of-day clock (hh:mm:ss) with a stored alarm and a ring-limited alarm FSM.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int RING_SECONDS = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       adjust_mode,
  input  logic       load,
  input  logic [1:0] adjusted,
  input  logic [4:0] time_hours_in,
  input  logic [5:0] time_minutes_in,
  input  logic [4:0] alarm_hours_in,
  input  logic [5:0] alarm_minutes_in,
  input  logic       alarm_enable,
  input  logic       stop,
  output logic [4:0] time_hours,
  output logic [5:0] time_minutes,
  output logic [5:0] time_seconds,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       alarm_ringing
);

  localparam logic [5:0] RING_LAST = 6'(RING_SECONDS - 1);

  logic time_load;
  logic alarm_load;
  logic count_en;
  logic sec_carry;
  logic min_carry;
  logic unused_day_carry;
  logic time_match;

  alarm_state_e state, state_next;
  logic [5:0]   ring_count, ring_count_next;

  // Out-of-range pairs are dropped independently of each other.
  assign time_load  = load && adjusted[0] && hhmm_valid(time_hours_in, time_minutes_in);
  assign alarm_load = load && adjusted[1] && hhmm_valid(alarm_hours_in, alarm_minutes_in);
  assign count_en   = tick_1hz && !adjust_mode;

  mod_n_counter #(.WIDTH(6), .MODULUS(int'(MAX_SECONDS) + 1)) u_seconds (
    .clk        (clk),
    .reset      (reset),
    .enable     (count_en),
    .load       (time_load),
    .load_value (6'd0),
    .count      (time_seconds),
    .carry      (sec_carry)
  );

  mod_n_counter #(.WIDTH(6), .MODULUS(int'(MAX_MINUTES) + 1)) u_minutes (
    .clk        (clk),
    .reset      (reset),
    .enable     (sec_carry),
    .load       (time_load),
    .load_value (time_minutes_in),
    .count      (time_minutes),
    .carry      (min_carry)
  );

  mod_n_counter #(.WIDTH(5), .MODULUS(int'(MAX_HOURS) + 1)) u_hours (
    .clk        (clk),
    .reset      (reset),
    .enable     (min_carry),
    .load       (time_load),
    .load_value (time_hours_in),
    .count      (time_hours),
    .carry      (unused_day_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_hours   <= '0;
      alarm_minutes <= '0;
    end else if (alarm_load) begin
      alarm_hours   <= alarm_hours_in;
      alarm_minutes <= alarm_minutes_in;
    end
  end

  assign time_match = (time_hours == alarm_hours) && (time_minutes == alarm_minutes);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a variable unassigned and infers a latch.
  always_comb begin
    state_next      = state;
    ring_count_next = ring_count;
    case (state)
      IDLE: begin
        if (alarm_enable && !adjust_mode && time_match && (time_seconds == 6'd0)) begin
          state_next      = RINGING;
          ring_count_next = '0;
        end
      end
      RINGING: begin
        if (tick_1hz) ring_count_next = ring_count + 1'b1;
        // The tick that brings the count to RING_SECONDS ends the ring on that same edge.
        if (stop || !alarm_enable || adjust_mode || (tick_1hz && (ring_count == RING_LAST))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // Hold until the matching minute has passed so the alarm cannot retrigger.
        if (!time_match) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ring_count    <= '0;
      alarm_ringing <= 1'b0;
    end else begin
      state         <= state_next;
      ring_count    <= ring_count_next;
      alarm_ringing <= (state_next == RINGING);
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: rollover, load rules, adjust freeze and the alarm FSM.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1hz;
  logic       adjust_mode;
  logic       load;
  logic [1:0] adjusted;
  logic [4:0] time_hours_in;
  logic [5:0] time_minutes_in;
  logic [4:0] alarm_hours_in;
  logic [5:0] alarm_minutes_in;
  logic       alarm_enable;
  logic       stop;
  logic [4:0] time_hours;
  logic [5:0] time_minutes;
  logic [5:0] time_seconds;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_ringing;

  int checks = 0;
  int errors = 0;

  time_keeper #(.RING_SECONDS(60)) dut (
    .clk              (clk),
    .reset            (reset),
    .tick_1hz         (tick_1hz),
    .adjust_mode      (adjust_mode),
    .load             (load),
    .adjusted         (adjusted),
    .time_hours_in    (time_hours_in),
    .time_minutes_in  (time_minutes_in),
    .alarm_hours_in   (alarm_hours_in),
    .alarm_minutes_in (alarm_minutes_in),
    .alarm_enable     (alarm_enable),
    .stop             (stop),
    .time_hours       (time_hours),
    .time_minutes     (time_minutes),
    .time_seconds     (time_seconds),
    .alarm_hours      (alarm_hours),
    .alarm_minutes    (alarm_minutes),
    .alarm_ringing    (alarm_ringing)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick_once();
      step();
    end
  endtask

  task automatic do_load(input logic [1:0] adj, input logic [4:0] th, input logic [5:0] tm,
                         input logic [4:0] ah, input logic [5:0] am);
    adjusted         = adj;
    time_hours_in    = th;
    time_minutes_in  = tm;
    alarm_hours_in   = ah;
    alarm_minutes_in = am;
    load             = 1'b1;
    step();
    load             = 1'b0;
    adjusted         = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; adjusted = 2'b11; tick_1hz = 1'b1;
    time_hours_in = 5'd12; time_minutes_in = 6'd34;
    alarm_hours_in = 5'd6; alarm_minutes_in = 6'd7;
    step();
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== 17'd0) begin
      errors++;
      $display("FAIL reset_time got %0d:%0d:%0d want 0:0:0", time_hours, time_minutes, time_seconds);
    end
    checks++;
    if ({alarm_hours, alarm_minutes} !== 11'd0) begin
      errors++;
      $display("FAIL reset_alarm got %0d:%0d want 0:0", alarm_hours, alarm_minutes);
    end
    checks++;
    if (alarm_ringing !== 1'b0) begin
      errors++;
      $display("FAIL reset_ringing got %b want 0", alarm_ringing);
    end
    reset = 1'b0; load = 1'b0; adjusted = 2'b00; tick_1hz = 1'b0;
    step();
  endtask

  task automatic test_rollover();
    do_load(2'b01, 5'd23, 6'd59, 5'd0, 6'd0);
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== {5'd23, 6'd59, 6'd0}) begin
      errors++;
      $display("FAIL roll_load got %0d:%0d:%0d want 23:59:0", time_hours, time_minutes, time_seconds);
    end
    tick_n(59);
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== {5'd23, 6'd59, 6'd59}) begin
      errors++;
      $display("FAIL roll_59 got %0d:%0d:%0d want 23:59:59", time_hours, time_minutes, time_seconds);
    end
    tick_n(1);
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== 17'd0) begin
      errors++;
      $display("FAIL roll_midnight got %0d:%0d:%0d want 0:0:0", time_hours, time_minutes, time_seconds);
    end
    do_load(2'b01, 5'd10, 6'd59, 5'd0, 6'd0);
    tick_n(60);
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== {5'd11, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL roll_hour got %0d:%0d:%0d want 11:0:0", time_hours, time_minutes, time_seconds);
    end
  endtask

  task automatic test_load_rules();
    do_load(2'b11, 5'd25, 6'd10, 5'd6, 6'd0);
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== {5'd11, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL bad_hours_time got %0d:%0d:%0d want 11:0:0", time_hours, time_minutes, time_seconds);
    end
    checks++;
    if ({alarm_hours, alarm_minutes} !== {5'd6, 6'd0}) begin
      errors++;
      $display("FAIL bad_hours_alarm got %0d:%0d want 6:0", alarm_hours, alarm_minutes);
    end
    do_load(2'b11, 5'd5, 6'd60, 5'd24, 6'd0);
    checks++;
    if ({time_hours, time_minutes, alarm_hours, alarm_minutes} !== {5'd11, 6'd0, 5'd6, 6'd0}) begin
      errors++;
      $display("FAIL bad_both got time %0d:%0d alarm %0d:%0d want 11:0 6:0",
               time_hours, time_minutes, alarm_hours, alarm_minutes);
    end
    do_load(2'b00, 5'd1, 6'd2, 5'd3, 6'd4);
    checks++;
    if ({time_hours, time_minutes, alarm_hours, alarm_minutes} !== {5'd11, 6'd0, 5'd6, 6'd0}) begin
      errors++;
      $display("FAIL adj_none got time %0d:%0d alarm %0d:%0d want 11:0 6:0",
               time_hours, time_minutes, alarm_hours, alarm_minutes);
    end
    do_load(2'b10, 5'd1, 6'd2, 5'd23, 6'd59);
    checks++;
    if ({time_hours, time_minutes, alarm_hours, alarm_minutes} !== {5'd11, 6'd0, 5'd23, 6'd59}) begin
      errors++;
      $display("FAIL alarm_only got time %0d:%0d alarm %0d:%0d want 11:0 23:59",
               time_hours, time_minutes, alarm_hours, alarm_minutes);
    end
    tick_n(5);
    do_load(2'b01, 5'd0, 6'd0, 5'd9, 6'd9);
    checks++;
    if ({time_hours, time_minutes, time_seconds, alarm_hours, alarm_minutes} !==
        {5'd0, 6'd0, 6'd0, 5'd23, 6'd59}) begin
      errors++;
      $display("FAIL time_only got %0d:%0d:%0d alarm %0d:%0d want 0:0:0 23:59",
               time_hours, time_minutes, time_seconds, alarm_hours, alarm_minutes);
    end
  endtask

  task automatic test_adjust_freeze();
    do_load(2'b01, 5'd12, 6'd0, 5'd0, 6'd0);
    tick_n(1);
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== {5'd12, 6'd0, 6'd1}) begin
      errors++;
      $display("FAIL adj_pre got %0d:%0d:%0d want 12:0:1", time_hours, time_minutes, time_seconds);
    end
    adjust_mode = 1'b1;
    tick_n(3);
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== {5'd12, 6'd0, 6'd1}) begin
      errors++;
      $display("FAIL adj_frozen got %0d:%0d:%0d want 12:0:1", time_hours, time_minutes, time_seconds);
    end
    tick_1hz = 1'b1;
    do_load(2'b01, 5'd12, 6'd5, 5'd0, 6'd0);
    tick_1hz = 1'b0;
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== {5'd12, 6'd5, 6'd0}) begin
      errors++;
      $display("FAIL adj_load_tick got %0d:%0d:%0d want 12:5:0", time_hours, time_minutes, time_seconds);
    end
    adjust_mode = 1'b0;
    tick_n(2);
    tick_1hz = 1'b1;
    do_load(2'b01, 5'd12, 6'd6, 5'd0, 6'd0);
    tick_1hz = 1'b0;
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== {5'd12, 6'd6, 6'd0}) begin
      errors++;
      $display("FAIL load_beats_tick got %0d:%0d:%0d want 12:6:0", time_hours, time_minutes, time_seconds);
    end
    tick_1hz = 1'b1;
    do_load(2'b10, 5'd0, 6'd0, 5'd7, 6'd30);
    tick_1hz = 1'b0;
    checks++;
    if ({time_hours, time_minutes, time_seconds, alarm_hours, alarm_minutes} !==
        {5'd12, 6'd6, 6'd1, 5'd7, 6'd30}) begin
      errors++;
      $display("FAIL alarm_load_tick got %0d:%0d:%0d alarm %0d:%0d want 12:6:1 7:30",
               time_hours, time_minutes, time_seconds, alarm_hours, alarm_minutes);
    end
  endtask

  task automatic test_alarm_trigger();
    alarm_enable = 1'b0;
    do_load(2'b01, 5'd7, 6'd29, 5'd0, 6'd0);
    tick_n(59);
    checks++;
    if ({time_hours, time_minutes, time_seconds} !== {5'd7, 6'd29, 6'd59}) begin
      errors++;
      $display("FAIL trig_pre got %0d:%0d:%0d want 7:29:59", time_hours, time_minutes, time_seconds);
    end
    alarm_enable = 1'b1;
    stop = 1'b1;
    step();
    stop = 1'b0;
    tick_once();
    checks++;
    if ({time_hours, time_minutes, time_seconds, alarm_ringing} !== {5'd7, 6'd30, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL trig_match got %0d:%0d:%0d ring %b want 7:30:0 ring 0",
               time_hours, time_minutes, time_seconds, alarm_ringing);
    end
    step();
    checks++;
    if (alarm_ringing !== 1'b1) begin
      errors++;
      $display("FAIL trig_ring got %b want 1", alarm_ringing);
    end
  endtask

  task automatic test_stop();
    logic rang = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (alarm_ringing !== 1'b0) begin
      errors++;
      $display("FAIL stop_drop got %b want 0", alarm_ringing);
    end
    for (int i = 0; i < 60; i++) begin
      tick_once();
      if (alarm_ringing !== 1'b0) rang = 1'b1;
      step();
      if (alarm_ringing !== 1'b0) rang = 1'b1;
    end
    checks++;
    if ({time_hours, time_minutes, time_seconds, rang} !== {5'd7, 6'd31, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL stop_hold got %0d:%0d:%0d rang %b want 7:31:0 rang 0",
               time_hours, time_minutes, time_seconds, rang);
    end
    step();
    do_load(2'b01, 5'd7, 6'd30, 5'd0, 6'd0);
    step();
    checks++;
    if (alarm_ringing !== 1'b1) begin
      errors++;
      $display("FAIL rearm got %b want 1", alarm_ringing);
    end
  endtask

  task automatic test_ring_timeout();
    tick_n(59);
    checks++;
    if (alarm_ringing !== 1'b1) begin
      errors++;
      $display("FAIL timeout_59 got %b want 1", alarm_ringing);
    end
    tick_once();
    checks++;
    if ({alarm_ringing, time_hours, time_minutes, time_seconds} !== {1'b0, 5'd7, 6'd31, 6'd0}) begin
      errors++;
      $display("FAIL timeout_60 ring %b time %0d:%0d:%0d want ring 0 7:31:0",
               alarm_ringing, time_hours, time_minutes, time_seconds);
    end
    step();
  endtask

  task automatic test_ring_abort();
    step();
    do_load(2'b01, 5'd7, 6'd30, 5'd0, 6'd0);
    step();
    alarm_enable = 1'b0;
    step();
    checks++;
    if (alarm_ringing !== 1'b0) begin
      errors++;
      $display("FAIL disable_drop got %b want 0", alarm_ringing);
    end
    alarm_enable = 1'b1;
    step(); step(); step();
    checks++;
    if (alarm_ringing !== 1'b0) begin
      errors++;
      $display("FAIL no_retrigger got %b want 0", alarm_ringing);
    end
    do_load(2'b01, 5'd7, 6'd31, 5'd0, 6'd0);
    step();
    do_load(2'b01, 5'd7, 6'd30, 5'd0, 6'd0);
    step();
    checks++;
    if (alarm_ringing !== 1'b1) begin
      errors++;
      $display("FAIL abort_ring got %b want 1", alarm_ringing);
    end
    adjust_mode = 1'b1;
    step();
    adjust_mode = 1'b0;
    checks++;
    if (alarm_ringing !== 1'b0) begin
      errors++;
      $display("FAIL adjust_drop got %b want 0", alarm_ringing);
    end
    do_load(2'b01, 5'd7, 6'd31, 5'd0, 6'd0);
    step();
    alarm_enable = 1'b0;
    do_load(2'b01, 5'd7, 6'd30, 5'd0, 6'd0);
    step(); step();
    checks++;
    if (alarm_ringing !== 1'b0) begin
      errors++;
      $display("FAIL disabled_match got %b want 0", alarm_ringing);
    end
    alarm_enable = 1'b1;
    step();
    checks++;
    if (alarm_ringing !== 1'b1) begin
      errors++;
      $display("FAIL enable_in_match got %b want 1", alarm_ringing);
    end
  endtask

  task automatic test_reset_mid_ring();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({alarm_ringing, time_hours, time_minutes, time_seconds, alarm_hours, alarm_minutes} !== 29'd0) begin
      errors++;
      $display("FAIL reset_ring ring %b time %0d:%0d:%0d alarm %0d:%0d want all 0",
               alarm_ringing, time_hours, time_minutes, time_seconds, alarm_hours, alarm_minutes);
    end
  endtask

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; adjust_mode = 1'b0; load = 1'b0; adjusted = 2'b00;
    time_hours_in = '0; time_minutes_in = '0; alarm_hours_in = '0; alarm_minutes_in = '0;
    alarm_enable = 1'b0; stop = 1'b0;
    step();
    test_reset();
    test_rollover();
    test_load_rules();
    test_adjust_freeze();
    test_alarm_trigger();
    test_stop();
    test_ring_timeout();
    test_ring_abort();
    test_reset_mid_ring();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
